// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory handshake between the fetch unit (master) and memory (slave).
// One request is outstanding at a time: req/addr are accepted with ready, and the
// instruction comes back later with rvalid/rdata.
interface pc_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC owner and single-outstanding instruction fetcher.
// Fetches at pc, holds the returned instruction for decode/execute, then takes
// back the branch/jump resolution on instr_ack to pick the next PC. External
// flush redirects at any point; misaligned control-flow targets divert to the
// trap vector with a one-cycle trap pulse.
module pc_fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pc_fetch_unit_if.master      imem,
    output logic                 instr_valid_o,
    output logic [31:0]          instr_o,
    output logic [XLEN-1:0]      instr_pc_o,
    output logic [XLEN-1:0]      link_addr_o,
    input  logic                 instr_ack_i,
    input  logic                 br_en_i,
    input  logic [2:0]           br_funct3_i,
    input  logic                 jal_i,
    input  logic                 jalr_i,
    input  logic [XLEN-1:0]      rs1_val_i,
    input  logic [XLEN-1:0]      rs2_val_i,
    input  logic [XLEN-1:0]      imm_i,
    input  logic                 flush_i,
    input  logic [XLEN-1:0]      flush_pc_i,
    output logic                 trap_valid_o,
    output logic [XLEN-1:0]      trap_epc_o,
    output logic [XLEN-1:0]      trap_tval_o,
    output logic [CNT_W-1:0]     retire_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              drop_q, drop_d;
    logic [31:0]       instr_q, instr_d;
    logic [XLEN-1:0]   instr_pc_q, instr_pc_d;
    logic [CNT_W-1:0]  retire_q, retire_d;
    logic              trap_valid_q, trap_valid_d;
    logic [XLEN-1:0]   trap_epc_q, trap_epc_d;
    logic [XLEN-1:0]   trap_tval_q, trap_tval_d;

    logic              br_taken;
    logic              redirect;
    logic [XLEN-1:0]   target;
    logic              misaligned;
    logic [XLEN-1:0]   resolved_pc;
    logic [XLEN-1:0]   flush_target;
    logic              accept;

    // Flush target is always word aligned; the two low bits of flush_pc are dropped.
    assign flush_target = flush_pc_i & ~XLEN'(3);

    // An acknowledged instruction retires only if no flush arrives with it.
    assign accept = (state_q == S_HOLD) && instr_ack_i && !flush_i;

    // Branch condition evaluation; 010/011 are not branch encodings and never take.
    always_comb begin
        br_taken = 1'b0;
        case (br_funct3_i)
            3'b000:  br_taken = (rs1_val_i == rs2_val_i);
            3'b001:  br_taken = (rs1_val_i != rs2_val_i);
            3'b100:  br_taken = ($signed(rs1_val_i) <  $signed(rs2_val_i));
            3'b101:  br_taken = ($signed(rs1_val_i) >= $signed(rs2_val_i));
            3'b110:  br_taken = (rs1_val_i <  rs2_val_i);
            3'b111:  br_taken = (rs1_val_i >= rs2_val_i);
            default: br_taken = 1'b0;
        endcase
    end

    // Next-PC selection: jalr over jal over taken branch over fall-through.
    always_comb begin
        redirect = 1'b1;
        target   = instr_pc_q + XLEN'(4);
        if (jalr_i) begin
            target = (rs1_val_i + imm_i) & ~XLEN'(1);
        end else if (jal_i || (br_en_i && br_taken)) begin
            target = instr_pc_q + imm_i;
        end else begin
            redirect = 1'b0;
        end
        misaligned  = redirect && (target[1:0] != 2'b00);
        resolved_pc = misaligned ? TRAP_VECTOR : target;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a flush only changes where fetching resumes, plus forcing
    // HOLD and a same-cycle WAIT response back to REQ.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ:  if (imem.imem_ready) state_d = S_WAIT;
            S_WAIT: if (imem.imem_rvalid) state_d = (drop_q || flush_i) ? S_REQ : S_HOLD;
            S_HOLD: if (flush_i || instr_ack_i) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        imem.imem_req = (state_q == S_REQ);
        instr_valid_o = (state_q == S_HOLD);
    end

    // Datapath next-state: pc, drop flag, held instruction, retire count, trap info.
    always_comb begin
        pc_d         = pc_q;
        drop_d       = drop_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        retire_d     = retire_q;
        trap_valid_d = 1'b0;
        trap_epc_d   = trap_epc_q;
        trap_tval_d  = trap_tval_q;

        if (flush_i) begin
            pc_d = flush_target;
        end else if (accept) begin
            pc_d = resolved_pc;
        end

        // A flush racing an accepted request leaves a stale response in flight.
        if (state_q == S_REQ && flush_i && imem.imem_ready) begin
            drop_d = 1'b1;
        end

        if (state_q == S_WAIT) begin
            if (imem.imem_rvalid) begin
                drop_d = 1'b0;
                if (!drop_q && !flush_i) begin
                    instr_d    = imem.imem_rdata;
                    instr_pc_d = pc_q;
                end
            end else if (flush_i) begin
                drop_d = 1'b1;
            end
        end

        if (accept) begin
            retire_d = retire_q + CNT_W'(1);
            if (misaligned) begin
                trap_valid_d = 1'b1;
                trap_epc_d   = instr_pc_q;
                trap_tval_d  = target;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_VECTOR;
            drop_q       <= 1'b0;
            instr_q      <= '0;
            instr_pc_q   <= '0;
            retire_q     <= '0;
            trap_valid_q <= 1'b0;
            trap_epc_q   <= '0;
            trap_tval_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            retire_q     <= retire_d;
            trap_valid_q <= trap_valid_d;
            trap_epc_q   <= trap_epc_d;
            trap_tval_q  <= trap_tval_d;
        end
    end

    assign imem.imem_addr = pc_q;
    assign instr_o        = instr_q;
    assign instr_pc_o     = instr_pc_q;
    // Link address is only meaningful while an instruction is held; zero otherwise.
    assign link_addr_o    = instr_valid_o ? (instr_pc_q + XLEN'(4)) : '0;
    assign trap_valid_o   = trap_valid_q;
    assign trap_epc_o     = trap_epc_q;
    assign trap_tval_o    = trap_tval_q;
    assign retire_cnt_o   = retire_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by random
// fetch/resolve traffic, checked against a behavioural PC model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pc_fetch_unit_if #(.XLEN(32)) imem_bus();

    logic        instr_valid;
    logic [31:0] instr, instr_pc, link_addr;
    logic        instr_ack, br_en, jal, jalr, flush;
    logic [2:0]  br_funct3;
    logic [31:0] rs1_val, rs2_val, imm, flush_pc;
    logic        trap_valid;
    logic [31:0] trap_epc, trap_tval, retire_cnt;

    pc_fetch_unit #(
        .XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .CNT_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .imem(imem_bus),
        .instr_valid_o(instr_valid), .instr_o(instr), .instr_pc_o(instr_pc),
        .link_addr_o(link_addr), .instr_ack_i(instr_ack), .br_en_i(br_en),
        .br_funct3_i(br_funct3), .jal_i(jal), .jalr_i(jalr),
        .rs1_val_i(rs1_val), .rs2_val_i(rs2_val), .imm_i(imm),
        .flush_i(flush), .flush_pc_i(flush_pc),
        .trap_valid_o(trap_valid), .trap_epc_o(trap_epc), .trap_tval_o(trap_tval),
        .retire_cnt_o(retire_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_ipc, m_retire;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {redirect, target} straight from the control-flow rules.
    function automatic logic [32:0] model_target(input logic [31:0] pc, input logic be,
                                                 input logic [2:0] f3, input logic j,
                                                 input logic jr, input logic [31:0] r1,
                                                 input logic [31:0] r2, input logic [31:0] im);
        logic taken;
        logic [31:0] sum;
        int s1, s2;
        s1 = int'(r1);
        s2 = int'(r2);
        case (f3)
            3'b000:  taken = (r1 == r2);
            3'b001:  taken = (r1 != r2);
            3'b100:  taken = (s1 < s2);
            3'b101:  taken = (s1 >= s2);
            3'b110:  taken = (longint'({32'b0, r1}) < longint'({32'b0, r2}));
            3'b111:  taken = (longint'({32'b0, r1}) >= longint'({32'b0, r2}));
            default: taken = 1'b0;
        endcase
        if (jr) begin
            sum = r1 + im;
            sum[0] = 1'b0;
            return {1'b1, sum};
        end
        if (j || (be && taken)) begin
            sum = pc + im;
            return {1'b1, sum};
        end
        sum = pc + 32'd4;
        return {1'b0, sum};
    endfunction

    task automatic clear_inputs();
        instr_ack = 0; br_en = 0; br_funct3 = 0; jal = 0; jalr = 0;
        rs1_val = 0; rs2_val = 0; imm = 0; flush = 0; flush_pc = 0;
    endtask

    // Waits for a request, optionally stalls ready / rvalid, ends with the instruction held.
    task automatic do_fetch(input int rdy_wait, input int rv_wait, input logic [31:0] data);
        int guard = 0;
        while (imem_bus.imem_req !== 1'b1 && guard < 10) begin
            tick();
            guard++;
        end
        check("req_seen", imem_bus.imem_req, 1);
        check("imem_addr", imem_bus.imem_addr, m_pc);
        for (int i = 0; i < rdy_wait; i++) begin
            if (i == 0) begin
                imem_bus.imem_rvalid = 1'b1;
                imem_bus.imem_rdata  = 32'hBAD0_0001;
            end
            tick();
            imem_bus.imem_rvalid = 1'b0;
            check("req_held", imem_bus.imem_req, 1);
            check("req_addr_held", imem_bus.imem_addr, m_pc);
        end
        imem_bus.imem_ready = 1'b1;
        tick();
        imem_bus.imem_ready = 1'b0;
        check("req_low_in_wait", imem_bus.imem_req, 0);
        check("trap_one_cycle", trap_valid, 0);
        for (int i = 0; i < rv_wait; i++) begin
            check("wait_no_valid", instr_valid, 0);
            tick();
        end
        imem_bus.imem_rvalid = 1'b1;
        imem_bus.imem_rdata  = data;
        tick();
        imem_bus.imem_rvalid = 1'b0;
        m_instr = data;
        m_ipc   = m_pc;
        check("instr_valid", instr_valid, 1);
        check("instr", instr, m_instr);
        check("instr_pc", instr_pc, m_ipc);
    endtask

    // Stalls in HOLD, then acks with the given resolution and checks the redirect.
    task automatic do_ack(input int stall, input logic be, input logic [2:0] f3,
                          input logic j, input logic jr, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] im);
        logic [32:0] res;
        logic        trap_exp;
        for (int i = 0; i < stall; i++) begin
            check("stall_valid", instr_valid, 1);
            check("stall_req", imem_bus.imem_req, 0);
            check("stall_instr", instr, m_instr);
            check("stall_pc", instr_pc, m_ipc);
            check("stall_retire", retire_cnt, m_retire);
            if (i == 0) begin
                imem_bus.imem_rvalid = 1'b1;
                imem_bus.imem_rdata  = ~m_instr;
            end
            tick();
            imem_bus.imem_rvalid = 1'b0;
        end
        check("hold_instr", instr, m_instr);
        check("link_addr", link_addr, m_ipc + 32'd4);
        br_en = be; br_funct3 = f3; jal = j; jalr = jr;
        rs1_val = r1; rs2_val = r2; imm = im; instr_ack = 1'b1;
        tick();
        clear_inputs();
        res      = model_target(m_ipc, be, f3, j, jr, r1, r2, im);
        trap_exp = res[32] && (res[1:0] != 2'b00);
        m_retire = m_retire + 32'd1;
        m_pc     = trap_exp ? TV : res[31:0];
        check("trap_valid", trap_valid, trap_exp);
        if (trap_exp) begin
            check("trap_epc", trap_epc, m_ipc);
            check("trap_tval", trap_tval, res[31:0]);
        end
        check("next_req", imem_bus.imem_req, 1);
        check("next_addr", imem_bus.imem_addr, m_pc);
        check("valid_drop", instr_valid, 0);
        check("retire_cnt", retire_cnt, m_retire);
        $display("ack pc=%h be=%0d f3=%0d jal=%0d jalr=%0d -> next=%h trap=%0d retire=%0d",
                 m_ipc, be, f3, j, jr, m_pc, trap_exp, m_retire);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_addr"}, imem_bus.imem_addr, RV);
        check({tag, "_req"}, imem_bus.imem_req, 0);
        check({tag, "_valid"}, instr_valid, 0);
        check({tag, "_instr"}, instr, 0);
        check({tag, "_ipc"}, instr_pc, 0);
        check({tag, "_link"}, link_addr, 0);
        check({tag, "_trap"}, trap_valid, 0);
        check({tag, "_epc"}, trap_epc, 0);
        check({tag, "_tval"}, trap_tval, 0);
        check({tag, "_retire"}, retire_cnt, 0);
    endtask

    task automatic flush_in_req(input logic [31:0] fpc);
        flush = 1'b1; flush_pc = fpc;
        tick();
        clear_inputs();
        m_pc = fpc & 32'hFFFF_FFFC;
        check("flush_req_stay", imem_bus.imem_req, 1);
        check("flush_req_addr", imem_bus.imem_addr, m_pc);
        $display("flush in REQ to %h", m_pc);
    endtask

    int t_hold[3];

    initial begin
        logic [31:0] r, r1, r2, im, data;
        int kind;
        clear_inputs();
        imem_bus.imem_ready  = 1'b0;
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata  = 32'h0;

        // Reset state
        #12;
        check_reset_state("reset");
        rst_n = 1'b1;
        m_pc = RV; m_retire = 0;

        // Back-to-back sequential fetches at full rate
        for (int k = 0; k < 3; k++) begin
            do_fetch(0, 0, 32'h0000_0013);
            t_hold[k] = cyc;
            do_ack(0, 0, 3'b000, 0, 0, 0, 0, 0);
        end
        check("seq_cadence1", t_hold[1] - t_hold[0], 3);
        check("seq_cadence2", t_hold[2] - t_hold[1], 3);
        check("seq_retire3", retire_cnt, 3);
        check("seq_addr_c", imem_bus.imem_addr, 32'hC);

        // Reach 0x10, then BLT taken (signed -1 < 1)
        do_fetch(0, 0, 32'h0000_0013);
        do_ack(0, 0, 3'b000, 0, 0, 0, 0, 0);
        do_fetch(1, 1, 32'h0000_0063);
        do_ack(0, 1, 3'b100, 0, 0, 32'hFFFF_FFFF, 32'h1, 32'h20);
        check("blt_taken", imem_bus.imem_addr, 32'h30);

        // Same operands, BLTU not taken
        flush_in_req(32'h0000_0011);
        do_fetch(0, 0, 32'h0000_0063);
        do_ack(0, 1, 3'b110, 0, 0, 32'hFFFF_FFFF, 32'h1, 32'h20);
        check("bltu_not_taken", imem_bus.imem_addr, 32'h14);

        // JALR to a misaligned target traps
        flush_in_req(32'h0000_0040);
        do_fetch(0, 0, 32'h0000_0067);
        do_ack(0, 0, 3'b000, 0, 1, 32'h1001, 0, 32'h2);
        check("jalr_trap_pulse", trap_valid, 1);
        check("jalr_trap_epc", trap_epc, 32'h40);
        check("jalr_trap_tval", trap_tval, 32'h1002);
        check("jalr_trap_vec", imem_bus.imem_addr, 32'h100);

        // JALR with bit0 cleared lands aligned
        flush_in_req(32'h0000_0040);
        do_fetch(0, 0, 32'h0000_0067);
        check("jalr_link", link_addr, 32'h44);
        do_ack(0, 0, 3'b000, 0, 1, 32'h1001, 0, 32'h3);
        check("jalr_aligned", imem_bus.imem_addr, 32'h1004);
        check("jalr_no_trap", trap_valid, 0);

        // Flush while waiting; late response is discarded
        imem_bus.imem_ready = 1'b1;
        tick();
        imem_bus.imem_ready = 1'b0;
        flush = 1'b1; flush_pc = 32'h203;
        tick();
        clear_inputs();
        check("wflush_wait", instr_valid, 0);
        tick();
        imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_bus.imem_rvalid = 1'b0;
        m_pc = 32'h200;
        check("wflush_discard", instr_valid, 0);
        check("wflush_req", imem_bus.imem_req, 1);
        check("wflush_addr", imem_bus.imem_addr, 32'h200);
        $display("flush in WAIT to %h, stale data dropped", m_pc);

        // Flush in REQ with ready high: response of the accepted request is dropped
        imem_bus.imem_ready = 1'b1; flush = 1'b1; flush_pc = 32'h302;
        tick();
        imem_bus.imem_ready = 1'b0; clear_inputs();
        check("rflush_wait", imem_bus.imem_req, 0);
        imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'hCAFE_0000;
        tick();
        imem_bus.imem_rvalid = 1'b0;
        m_pc = 32'h300;
        check("rflush_discard", instr_valid, 0);
        check("rflush_addr", imem_bus.imem_addr, 32'h300);
        check("rflush_req", imem_bus.imem_req, 1);

        // Flush in WAIT coinciding with rvalid
        imem_bus.imem_ready = 1'b1;
        tick();
        imem_bus.imem_ready = 1'b0;
        flush = 1'b1; flush_pc = 32'h404;
        imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h1234_5678;
        tick();
        imem_bus.imem_rvalid = 1'b0; clear_inputs();
        m_pc = 32'h404;
        check("sflush_discard", instr_valid, 0);
        check("sflush_addr", imem_bus.imem_addr, 32'h404);
        check("sflush_req", imem_bus.imem_req, 1);

        // Stall in HOLD, then flush wins over jal+ack
        do_fetch(0, 0, 32'h0400_006F);
        for (int i = 0; i < 5; i++) begin
            check("stall5_valid", instr_valid, 1);
            check("stall5_instr", instr, 32'h0400_006F);
            check("stall5_pc", instr_pc, 32'h404);
            check("stall5_req", imem_bus.imem_req, 0);
            check("stall5_retire", retire_cnt, m_retire);
            tick();
        end
        jal = 1'b1; imm = 32'h40; instr_ack = 1'b1; flush = 1'b1; flush_pc = 32'h501;
        tick();
        clear_inputs();
        m_pc = 32'h500;
        check("hflush_valid", instr_valid, 0);
        check("hflush_addr", imem_bus.imem_addr, 32'h500);
        check("hflush_retire", retire_cnt, m_retire);
        check("hflush_trap", trap_valid, 0);
        $display("flush over jal+ack in HOLD -> %h", m_pc);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            data = $urandom;
            do_fetch($urandom_range(0, 2), $urandom_range(0, 2), data);
            r  = $urandom;
            im = {{20{r[11]}}, r[11:2], 2'b00};
            if ($urandom_range(0, 5) == 0) im[1:0] = 2'($urandom_range(1, 3));
            r1 = $urandom;
            r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
            kind = $urandom_range(0, 5);
            case (kind)
                0: do_ack($urandom_range(0, 2), 0, 3'b000, 0, 0, r1, r2, im);
                1, 2: do_ack($urandom_range(0, 2), 1, 3'($urandom_range(0, 7)), 0, 0, r1, r2, im);
                3: do_ack($urandom_range(0, 2), 0, 3'b000, 1, 0, r1, r2, im);
                4: do_ack($urandom_range(0, 2), 0, 3'b000, 0, 1, r1, r2, im);
                default: do_ack($urandom_range(0, 2), 1, 3'($urandom_range(0, 7)), 1'($urandom),
                                1'($urandom), r1, r2, im);
            endcase
        end

        // Asynchronous reset in the middle of an outstanding request
        imem_bus.imem_ready = 1'b1;
        tick();
        imem_bus.imem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        tick();
        rst_n = 1'b1;
        m_pc = RV; m_retire = 0;
        do_fetch(0, 0, 32'h0000_0013);
        do_ack(0, 0, 3'b000, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Parametrised successor to the core's PC register. Owns the PC and fetches over a handshaked instruction-memory port with one outstanding request. Presents each fetched instruction to decode/execute and takes back the branch/jump resolution. Resolves the full RV32I branch set, JAL and JALR internally, and adds external flush, misaligned-target trap and a retire counter.

Parameters:
XLEN, 32, datapath/address width
RESET_VECTOR, 32'h0000_0000, PC loaded at reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned target
CNT_W, 32, retire counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address (= pc)
imem_ready  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  32  response instruction
instr_valid  out  1  instr/instr_pc valid
instr  out  32  held instruction
instr_pc  out  XLEN  PC of held instruction
link_addr  out  XLEN  instr_pc+4, combinational
instr_ack  in  1  consumer accepts instr; resolution inputs sampled this cycle
br_en  in  1  conditional branch
br_funct3  in  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
jal  in  1  JAL
jalr  in  1  JALR
rs1_val  in  XLEN  operand 1
rs2_val  in  XLEN  operand 2
imm  in  XLEN  sign-extended immediate
flush  in  1  external redirect
flush_pc  in  XLEN  redirect target, bits[1:0] ignored (treated 00)
trap_valid  out  1  one-cycle misaligned-target pulse
trap_epc  out  XLEN  instr_pc of trapping instruction
trap_tval  out  XLEN  offending target
retire_cnt  out  CNT_W  acked instructions, wraps

Behaviour:
- Reset (async, rst_n low): state IDLE, pc=RESET_VECTOR, drop=0. All outputs 0 except imem_addr=RESET_VECTOR.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE -> REQ: unconditional, next cycle.
- REQ: imem_req=1, imem_addr=pc. On imem_ready go WAIT.
- WAIT: on imem_rvalid: if drop=0, latch instr=imem_rdata, instr_pc=pc, go HOLD; if drop=1, discard data, clear drop, go REQ.
- HOLD: instr_valid=1. On instr_ack, load pc with next PC, retire_cnt+1 (wraps at 2^CNT_W), go REQ.
- Minimum latency is 3 cycles per instruction: REQ(ready) -> WAIT(rvalid) -> HOLD(ack).
- rvalid in any state other than WAIT is ignored. imem_ready outside REQ is ignored.
- Next PC, priority jalr > jal > br_en > sequential:
  - jalr: (rs1_val+imm) & ~1
  - jal: instr_pc+imm
  - br_en and taken: instr_pc+imm
  - otherwise: instr_pc+4
  - All adds are modulo 2^XLEN.
- Branch compare: signed for BLT/BGE, unsigned for BLTU/BGEU. br_funct3 010/011 means not taken.
- Misaligned target: computed target[1:0]!=0 on a jal/jalr/taken branch. Then pc=TRAP_VECTOR, trap_valid=1 for one cycle, trap_epc=instr_pc, trap_tval=target. Instruction still counts as retired.
- flush has priority over instr_ack and sets pc={flush_pc[XLEN-1:2],2'b00}:
  - IDLE/HOLD: go REQ; instr_valid drops next cycle; no retire.
  - REQ with imem_ready low: stay REQ at the new pc.
  - REQ with imem_ready high: go WAIT with drop=1.
  - WAIT without rvalid: set drop=1, stay WAIT.
  - WAIT with rvalid same cycle: discard data, go REQ.
- Reset mid-transaction abandons any outstanding request. The memory side must discard it.

Test Plan:
- Reset release, imem_ready=1 and rvalid next cycle with 0x00000013 -> imem_addr 0x0, 0x4, 0x8 on successive requests; instr_valid every 3rd cycle; retire_cnt=3 after 3 acks.
- Ack at instr_pc=0x10 with br_en, funct3=100, rs1=0xFFFFFFFF, rs2=1, imm=0x20 -> next imem_addr 0x30. Same inputs with funct3=110 -> 0x14.
- Ack at instr_pc=0x40 with jalr, rs1=0x1001, imm=2 -> target 0x1002 misaligned -> trap_valid one cycle, trap_epc=0x40, trap_tval=0x1002, next imem_addr=0x100.
- Ack at instr_pc=0x40 with jalr, rs1=0x1001, imm=3 -> target 0x1004 -> next fetch 0x1004, no trap, link_addr=0x44.
- Flush to 0x203 while in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> data discarded, instr_valid stays 0, next imem_addr=0x200.
- Stall: hold instr_ack=0 for 5 cycles in HOLD -> instr/instr_pc stable, imem_req=0, retire_cnt unchanged; asserting jal and ack together with flush -> flush target wins.
